sevseg_disp_sched: RTL and testbench
====================================

Name: sevseg_disp_sched

Overview:
- Scheduler that owns the 32-bit hex value feeding the 8-digit seven-segment scanner.
- Shows a background value (live score) by default.
- Accepts transient message requests (goal, game over, serve) over valid/ready handshakes and shows each for a fixed hold time, then returns to background.
- Fixed-priority arbitration between message requesters, with no preemption of a message already on display.

Parameters:
- NUM_MSG, 2, number of message requester ports (1..4); higher index = higher priority.
- HOLD_CYCLES, 150_000_000, clk cycles a granted message stays on the display (>= 2).

Ports:
- clk  input  1  system clock.
- arst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous abort; drops the current message, returns to background.
- bg_val  input  32  background hex value (8 nibbles, digit 0 = bits [3:0]).
- msg_valid  input  NUM_MSG  per-requester request valid.
- msg_data  input  NUM_MSG*32  per-requester message value; requester i uses bits [i*32 +: 32].
- msg_ready  output  NUM_MSG  per-requester accept strobe (combinational).
- sevseg_32bit_hex_val  output  32  registered value sent to the display scanner.
- active_src  output  3  0 = background, i+1 = message from requester i (registered).
- busy  output  1  high while a message is held (registered).

Behaviour:
- Reset (arst_n low, async):
  - State IDLE, hex_val = 32'h0, active_src = 0, busy = 0, hold counter = 0.
  - No msg_ready asserted while arst_n is low.
- State IDLE:
  - hex_val <= bg_val every cycle, so background has 1-cycle latency; active_src <= 0; busy <= 0.
  - Grant = highest index i with msg_valid[i] = 1; msg_ready[i] = 1 for that index only, same cycle, combinationally.
  - All other msg_ready bits are 0.
  - Accept = msg_valid[i] & msg_ready[i].
  - On accept, msg_data slice i is latched, hex_val <= that value on the next edge, active_src <= i+1, busy <= 1, counter <= HOLD_CYCLES-1, and the state goes to SHOW.
- State SHOW:
  - msg_ready = all zeros; hex_val holds the latched message regardless of bg_val or msg_data changes.
  - Counter decrements by 1 per cycle. When counter = 0, the next state is IDLE.
  - The message is therefore visible for exactly HOLD_CYCLES cycles.
- Back-to-back:
  - IDLE is occupied for at least 1 cycle between messages, so background is visible for at least 1 cycle.
  - A pending request is granted in that first IDLE cycle.
- Requesters must hold msg_valid and msg_data stable until accepted. A valid dropped before acceptance is simply never granted; no error is flagged.
- clear:
  - Priority over everything. In any state, the next state is IDLE, hex_val <= bg_val, active_src <= 0, busy <= 0, counter <= 0.
  - msg_ready is forced to 0 during the clear cycle, so nothing is accepted.
- Simultaneous valids: the highest index wins; lower requesters stay pending and are served in later IDLE windows, in priority order.
- Starvation: allowed by design. The highest-priority requester reasserting every IDLE window blocks the lower ones.
- Counter width: $clog2(HOLD_CYCLES). The counter never wraps: it is loaded only on accept and stops at 0.
- hex_val, active_src and busy are all registered, with no combinational path from inputs.

Test Plan:
- Reset/background: assert arst_n low mid-SHOW with NUM_MSG=2, HOLD_CYCLES=4.
  - While low: hex_val = 0, busy = 0, msg_ready = 0.
  - After release with bg_val = 32'h0000_0312: hex_val = 32'h0000_0312 one cycle later.
- Single message: msg_valid[0] = 1, data 32'hAAAA_0001 in IDLE.
  - msg_ready[0] = 1 that cycle.
  - hex_val = AAAA_0001 and active_src = 1 for exactly 4 cycles, then bg_val again; busy high for the same 4 cycles.
- Priority: msg_valid = 2'b11, data0 = 32'h1111_1111, data1 = 32'h2222_2222.
  - Requester 1 shown for 4 cycles, then 1 background cycle, then requester 0 shown for 4 cycles.
  - msg_ready[0] stays 0 until that IDLE cycle.
- Hold stability: during SHOW, change bg_val and data1 every cycle.
  - hex_val constant at the latched value; msg_ready = 0 throughout.
- Clear: pulse clear on the 2nd SHOW cycle.
  - Next cycle hex_val = bg_val, busy = 0, active_src = 0.
  - A valid held during the clear cycle is accepted on the following cycle.
- Simultaneous clear + new valid in IDLE: no acceptance that cycle; accepted the cycle after clear drops.

Source files
------------

// File: rtl/sevseg_disp_sched.sv
// Display-value scheduler for the 8-digit seven-segment scanner: shows a background
// value and, on request, holds one fixed-priority message for HOLD_CYCLES cycles.
module sevseg_disp_sched #(
   parameter int NUM_MSG     = 2,
   parameter int HOLD_CYCLES = 150_000_000
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  clear,
   input  logic [31:0]           bg_val,
   input  logic [NUM_MSG-1:0]    msg_valid,
   input  logic [NUM_MSG*32-1:0] msg_data,
   output logic [NUM_MSG-1:0]    msg_ready,
   output logic [31:0]           sevseg_32bit_hex_val,
   output logic [2:0]            active_src,
   output logic                  busy
);

   localparam int CNT_W = $clog2(HOLD_CYCLES);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_nxt_s;
   logic [31:0]        hex_r;
   logic [31:0]        hex_nxt_s;
   logic [2:0]         src_r;
   logic [2:0]         src_nxt_s;
   logic               busy_r;
   logic               busy_nxt_s;

   logic               grant_vld_s;
   logic [1:0]         grant_idx_s;
   logic [31:0]        grant_data_s;
   logic               accept_s;

   // Fixed-priority pick: ascending scan so the highest valid index wins.
   always_comb begin
      grant_vld_s  = 1'b0;
      grant_idx_s  = 2'd0;
      grant_data_s = 32'h0000_0000;
      for (int i = 0; i < NUM_MSG; i++) begin
         grant_vld_s  = grant_vld_s | msg_valid[i];
         grant_idx_s  = msg_valid[i] ? 2'(i) : grant_idx_s;
         grant_data_s = msg_valid[i] ? msg_data[i*32 +: 32] : grant_data_s;
      end
   end

   // Ready is gated by reset too, so nothing is offered while the block is held in reset.
   assign accept_s = arst_n & ~clear & (state_r == ST_IDLE) & grant_vld_s;

   // One-hot ready strobe toward the winning requester.
   always_comb begin
      msg_ready = {NUM_MSG{1'b0}};
      for (int i = 0; i < NUM_MSG; i++) begin
         msg_ready[i] = accept_s & (grant_idx_s == 2'(i));
      end
   end

   // Next-state and next-output selection; clear overrides every state.
   always_comb begin
      state_nxt_s = ST_IDLE;
      hex_nxt_s   = bg_val;
      src_nxt_s   = 3'd0;
      busy_nxt_s  = 1'b0;
      cnt_nxt_s   = {CNT_W{1'b0}};
      if (clear) begin
         state_nxt_s = ST_IDLE;
         hex_nxt_s   = bg_val;
         src_nxt_s   = 3'd0;
         busy_nxt_s  = 1'b0;
         cnt_nxt_s   = {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  state_nxt_s = ST_SHOW;
                  hex_nxt_s   = grant_data_s;
                  src_nxt_s   = {1'b0, grant_idx_s} + 3'd1;
                  busy_nxt_s  = 1'b1;
                  cnt_nxt_s   = CNT_W'(HOLD_CYCLES - 1);
               end else begin
                  state_nxt_s = ST_IDLE;
                  hex_nxt_s   = bg_val;
                  src_nxt_s   = 3'd0;
                  busy_nxt_s  = 1'b0;
                  cnt_nxt_s   = cnt_r;
               end
            end
            ST_SHOW: begin
               // Leaving on the zero count keeps the message up for exactly HOLD_CYCLES.
               if (cnt_r == {CNT_W{1'b0}}) begin
                  state_nxt_s = ST_IDLE;
                  hex_nxt_s   = bg_val;
                  src_nxt_s   = 3'd0;
                  busy_nxt_s  = 1'b0;
                  cnt_nxt_s   = {CNT_W{1'b0}};
               end else begin
                  state_nxt_s = ST_SHOW;
                  hex_nxt_s   = hex_r;
                  src_nxt_s   = src_r;
                  busy_nxt_s  = 1'b1;
                  cnt_nxt_s   = cnt_r - CNT_W'(1);
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               hex_nxt_s   = bg_val;
               src_nxt_s   = 3'd0;
               busy_nxt_s  = 1'b0;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // State, hold counter and registered display outputs.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         hex_r   <= 32'h0000_0000;
         src_r   <= 3'd0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         hex_r   <= hex_nxt_s;
         src_r   <= src_nxt_s;
         busy_r  <= busy_nxt_s;
      end
   end

   assign sevseg_32bit_hex_val = hex_r;
   assign active_src           = src_r;
   assign busy                 = busy_r;

endmodule

// File: tb/tb_sevseg_disp_sched.sv
// Self-checking bench for sevseg_disp_sched (NUM_MSG=2, HOLD_CYCLES=4): a per-cycle
// vector table with hand-derived expectations, plus a hand-written reset-during-SHOW sequence.
module tb_sevseg_disp_sched;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        clear;
   logic [31:0] bg_val;
   logic [1:0]  msg_valid;
   logic [63:0] msg_data;
   logic [1:0]  msg_ready;
   logic [31:0] hex_val;
   logic [2:0]  active_src;
   logic        busy;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   typedef struct {
      logic        clr;
      logic [31:0] bg;
      logic [1:0]  vld;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  exp_rdy;
      logic [31:0] exp_hex;
      logic [2:0]  exp_src;
      logic        exp_busy;
   } row_t;

   typedef struct {
      int          row;
      logic [31:0] hex;
      logic [2:0]  src;
      logic        busy;
   } exp_t;

   row_t tbl[$];
   exp_t sb_q[$];

   sevseg_disp_sched #(.NUM_MSG(2), .HOLD_CYCLES(4)) dut (
      .clk                  (clk),
      .arst_n               (arst_n),
      .clear                (clear),
      .bg_val               (bg_val),
      .msg_valid            (msg_valid),
      .msg_data             (msg_data),
      .msg_ready            (msg_ready),
      .sevseg_32bit_hex_val (hex_val),
      .active_src           (active_src),
      .busy                 (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic add(input logic clr, input logic [31:0] bg, input logic [1:0] vld,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] rdy,
                      input logic [31:0] hex, input logic [2:0] src, input logic bsy);
      row_t r;
      r.clr = clr; r.bg = bg; r.vld = vld; r.d0 = d0; r.d1 = d1;
      r.exp_rdy = rdy; r.exp_hex = hex; r.exp_src = src; r.exp_busy = bsy;
      tbl.push_back(r);
   endtask

   // Called at a negedge: drive one row, check the combinational ready, then the registered outputs.
   task automatic run_row(input int idx);
      row_t r;
      exp_t e;
      r = tbl[idx];
      clear     = r.clr;
      bg_val    = r.bg;
      msg_valid = r.vld;
      msg_data  = {r.d1, r.d0};
      #1;
      check($sformatf("row%0d_ready", idx), {30'd0, msg_ready}, {30'd0, r.exp_rdy});
      e.row = idx; e.hex = r.exp_hex; e.src = r.exp_src; e.busy = r.exp_busy;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      check($sformatf("row%0d_hex", e.row), hex_val, e.hex);
      check($sformatf("row%0d_src", e.row), {29'd0, active_src}, {29'd0, e.src});
      check($sformatf("row%0d_busy", e.row), {31'd0, busy}, {31'd0, e.busy});
   endtask

   initial begin
      // clr, bg, vld, d0, d1 | ready, hex, src, busy after the edge
      add(1'b0, 32'h0000_0312, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0000_0312, 3'd0, 1'b0);
      add(1'b0, 32'h0000_0555, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0000_0555, 3'd0, 1'b0);
      // single message from requester 0
      add(1'b0, 32'h0000_0555, 2'b01, 32'hAAAA_0001, 32'h0, 2'b01, 32'hAAAA_0001, 3'd1, 1'b1);
      add(1'b0, 32'h0000_0555, 2'b00, 32'h0, 32'h0, 2'b00, 32'hAAAA_0001, 3'd1, 1'b1);
      add(1'b0, 32'h0000_0555, 2'b00, 32'h0, 32'h0, 2'b00, 32'hAAAA_0001, 3'd1, 1'b1);
      add(1'b0, 32'h0000_0555, 2'b00, 32'h0, 32'h0, 2'b00, 32'hAAAA_0001, 3'd1, 1'b1);
      add(1'b0, 32'h0000_0555, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0000_0555, 3'd0, 1'b0);
      // both valid: requester 1 wins, inputs churn during the hold
      add(1'b0, 32'h0000_0555, 2'b11, 32'h1111_1111, 32'h2222_2222, 2'b10, 32'h2222_2222, 3'd2, 1'b1);
      add(1'b0, 32'h0000_0001, 2'b11, 32'h1111_1111, 32'hDEAD_0001, 2'b00, 32'h2222_2222, 3'd2, 1'b1);
      add(1'b0, 32'h0000_0002, 2'b11, 32'h1111_1111, 32'hDEAD_0002, 2'b00, 32'h2222_2222, 3'd2, 1'b1);
      add(1'b0, 32'h0000_0003, 2'b01, 32'h1111_1111, 32'hDEAD_0003, 2'b00, 32'h2222_2222, 3'd2, 1'b1);
      add(1'b0, 32'h0000_0004, 2'b01, 32'h1111_1111, 32'h0, 2'b00, 32'h0000_0004, 3'd0, 1'b0);
      // pending requester 0 granted in the single background cycle
      add(1'b0, 32'h0000_0005, 2'b01, 32'h1111_1111, 32'h0, 2'b01, 32'h1111_1111, 3'd1, 1'b1);
      add(1'b0, 32'h0000_0006, 2'b00, 32'h0, 32'h0, 2'b00, 32'h1111_1111, 3'd1, 1'b1);
      add(1'b0, 32'h0000_0006, 2'b00, 32'h0, 32'h0, 2'b00, 32'h1111_1111, 3'd1, 1'b1);
      add(1'b0, 32'h0000_0006, 2'b00, 32'h0, 32'h0, 2'b00, 32'h1111_1111, 3'd1, 1'b1);
      add(1'b0, 32'h0000_0007, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0000_0007, 3'd0, 1'b0);
      // clear on the 2nd SHOW cycle, with requester 0 waiting
      add(1'b0, 32'h0000_0007, 2'b10, 32'h0, 32'h3333_3333, 2'b10, 32'h3333_3333, 3'd2, 1'b1);
      add(1'b0, 32'h0000_0007, 2'b00, 32'h0, 32'h0, 2'b00, 32'h3333_3333, 3'd2, 1'b1);
      add(1'b1, 32'h0000_0008, 2'b01, 32'h4444_4444, 32'h0, 2'b00, 32'h0000_0008, 3'd0, 1'b0);
      add(1'b0, 32'h0000_0008, 2'b01, 32'h4444_4444, 32'h0, 2'b01, 32'h4444_4444, 3'd1, 1'b1);
      add(1'b0, 32'h0000_0008, 2'b00, 32'h0, 32'h0, 2'b00, 32'h4444_4444, 3'd1, 1'b1);
      add(1'b0, 32'h0000_0008, 2'b00, 32'h0, 32'h0, 2'b00, 32'h4444_4444, 3'd1, 1'b1);
      add(1'b0, 32'h0000_0008, 2'b00, 32'h0, 32'h0, 2'b00, 32'h4444_4444, 3'd1, 1'b1);
      add(1'b0, 32'h0000_0008, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0000_0008, 3'd0, 1'b0);
      // clear together with a new valid in IDLE
      add(1'b1, 32'h0000_0009, 2'b10, 32'h0, 32'h5555_5555, 2'b00, 32'h0000_0009, 3'd0, 1'b0);
      add(1'b0, 32'h0000_0009, 2'b10, 32'h0, 32'h5555_5555, 2'b10, 32'h5555_5555, 3'd2, 1'b1);
      add(1'b0, 32'h0000_0009, 2'b00, 32'h0, 32'h0, 2'b00, 32'h5555_5555, 3'd2, 1'b1);

      // power-on reset with a request present: nothing offered, outputs cleared
      arst_n    = 1'b0;
      clear     = 1'b0;
      bg_val    = 32'h0000_0312;
      msg_valid = 2'b01;
      msg_data  = {32'h0, 32'hAAAA_0001};
      @(negedge clk);
      #1;
      check("por_ready", {30'd0, msg_ready}, 32'd0);
      check("por_hex", hex_val, 32'h0000_0000);
      check("por_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      msg_valid = 2'b00;
      arst_n    = 1'b1;

      for (int i = 0; i < tbl.size(); i++) run_row(i);

      // async reset in the middle of the 5555_5555 hold
      msg_valid = 2'b11;
      msg_data  = {32'h6666_6666, 32'h7777_7777};
      arst_n    = 1'b0;
      #1;
      check("rst_show_hex", hex_val, 32'h0000_0000);
      check("rst_show_busy", {31'd0, busy}, 32'd0);
      check("rst_show_src", {29'd0, active_src}, 32'd0);
      check("rst_show_ready", {30'd0, msg_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("rst_hold_ready", {30'd0, msg_ready}, 32'd0);
      check("rst_hold_hex", hex_val, 32'h0000_0000);
      msg_valid = 2'b00;
      bg_val    = 32'h0000_0312;
      arst_n    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_rel_hex", hex_val, 32'h0000_0312);
      check("rst_rel_busy", {31'd0, busy}, 32'd0);
      check("rst_rel_src", {29'd0, active_src}, 32'd0);
      if (sb_q.size() != 0) check("sb_empty", sb_q.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
